// File: rtl/datapath_unit.sv
// datapath_unit: register file, shared internal bus and a single-port word RAM
// behind a wait-state handshake, driven by the sequencing controller's strobes.
// Optional feature macro: DP_BUS_CHECK_EN
//   defined   -> multi-driver bus cycles force bus = 0 and set sticky bus_err;
//                a simultaneous read+write request also sets bus_err.
//   undefined -> bus_err tied 0; multiple drivers resolve PC > IR > MBR.
// Port names follow the controller interface, so they carry no _i/_o suffixes.

module datapath_unit #(
    parameter int WIDTH    = 8,
    parameter int AW       = 4,
    parameter int WAIT_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             PC_in,
    input  logic             PC_out,
    input  logic             inc_PC,
    input  logic             MAR_in,
    input  logic             MAR_mramout,
    input  logic             dram_in,
    input  logic             dram_out,
    input  logic             data_in,
    input  logic             data_out,
    input  logic             en,
    input  logic             IR_in,
    input  logic             IR_out,
    input  logic             Y_in,
    output logic [WIDTH-1:0] bus,
    output logic [AW-1:0]    pc_q,
    output logic [AW-1:0]    mar_q,
    output logic [WIDTH-1:0] ir_q,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] mbr_q,
    output logic             ready,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    mem_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    // NOTE: the RAM has no reset; its contents are undefined until written,
    // so it lives in a clock-only process outside the async-reset registers.
    logic [WIDTH-1:0] mem_q [2**AW];

    logic req;
    logic mem_rd_done;
    logic mem_wr_done;

    assign req         = en & (data_in | data_out);
    assign mem_rd_done = (state_q == S_DONE) & ~wr_q;
    assign mem_wr_done = (state_q == S_DONE) &  wr_q;

`ifdef DP_BUS_CHECK_EN
    logic drv_multi;
    logic rw_conflict;
    logic bus_err_q;

    assign drv_multi   = (PC_out & IR_out) | (PC_out & dram_out) | (IR_out & dram_out);
    assign rw_conflict = (state_q == S_IDLE) & en & data_in & data_out;
`endif

    // Internal bus: priority mux of PC (zero-extended), IR, MBR; idle bus reads 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        bus = '0;
        if (PC_out) begin
            bus = WIDTH'(pc_q);
        end else if (IR_out) begin
            bus = ir_q;
        end else if (dram_out) begin
            bus = mbr_q;
        end
`ifdef DP_BUS_CHECK_EN
        if (drv_multi) begin
            bus = '0;
        end
`endif
    end

    // Programmer-visible registers; each samples the bus of the strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            pc_q  <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
        end else begin
            if (PC_in) begin
                pc_q <= bus[AW-1:0];
            end else if (inc_PC) begin
                pc_q <= pc_q + AW'(1);
            end
            if (MAR_in) begin
                mar_q <= bus[AW-1:0];
            end
            if (IR_in) begin
                ir_q <= bus;
            end
            if (Y_in) begin
                y_q <= bus;
            end
        end
    end

    // MBR: completing memory read takes precedence over a bus load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mbr_q <= '0;
        end else if (mem_rd_done) begin
            mbr_q <= mem_q[addr_q];
        end else if (dram_in) begin
            mbr_q <= bus;
        end
    end

    // Memory FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory FSM next state plus the access context captured at request time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = MAR_mramout ? mar_q : pc_q;
                    wr_d    = data_in;      // write wins a read+write request
                    wdata_d = mbr_q;
                    if (WAIT_CYC == 0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = 4'(WAIT_CYC);
                    end
                end
            end
            S_BUSY: begin
                // Strobes are ignored while the access is in flight.
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter and latched access context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Handshake output: ready for exactly the DONE cycle.
    always_comb begin
        ready = (state_q == S_DONE);
    end

    // RAM write port; an access aborted by reset never reaches DONE.
    always_ff @(posedge clk) begin
        if (mem_wr_done) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

`ifdef DP_BUS_CHECK_EN
    // Sticky error flag for multi-driver bus cycles and read+write requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else if (drv_multi | rw_conflict) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed scenarios plus a randomized
// run against a transaction-level model (registers, bus value, RAM array).
module tb_datapath_unit;

    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int WAIT1 = 1;

    typedef struct packed {
        logic pc_in, pc_out, inc_pc, mar_in, mar_sel, dram_in, dram_out;
        logic data_in, data_out, en, ir_in, ir_out, y_in;
    } strobes_t;

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] mar;
        logic [7:0] ir;
        logic [7:0] y;
        logic [7:0] mbr;
        logic       err;
    } view_t;

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    strobes_t s1 = '0;
    strobes_t s0 = '0;

    logic [7:0] bus1, ir1, y1, mbr1, bus0, ir0, y0, mbr0;
    logic [3:0] pc1, mar1, pc0, mar0;
    logic       ready1, err1, ready0, err0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_y, m_mbr;
    logic       m_err;
    logic [7:0] m_mem [16];

    always #5 clk = ~clk;

    datapath_unit #(.WIDTH(WIDTH), .AW(AW), .WAIT_CYC(WAIT1)) u_dut (
        .clk(clk), .reset(reset),
        .PC_in(s1.pc_in), .PC_out(s1.pc_out), .inc_PC(s1.inc_pc),
        .MAR_in(s1.mar_in), .MAR_mramout(s1.mar_sel),
        .dram_in(s1.dram_in), .dram_out(s1.dram_out),
        .data_in(s1.data_in), .data_out(s1.data_out), .en(s1.en),
        .IR_in(s1.ir_in), .IR_out(s1.ir_out), .Y_in(s1.y_in),
        .bus(bus1), .pc_q(pc1), .mar_q(mar1), .ir_q(ir1), .y_q(y1),
        .mbr_q(mbr1), .ready(ready1), .bus_err(err1)
    );

    datapath_unit #(.WIDTH(WIDTH), .AW(AW), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .PC_in(s0.pc_in), .PC_out(s0.pc_out), .inc_PC(s0.inc_pc),
        .MAR_in(s0.mar_in), .MAR_mramout(s0.mar_sel),
        .dram_in(s0.dram_in), .dram_out(s0.dram_out),
        .data_in(s0.data_in), .data_out(s0.data_out), .en(s0.en),
        .IR_in(s0.ir_in), .IR_out(s0.ir_out), .Y_in(s0.y_in),
        .bus(bus0), .pc_q(pc0), .mar_q(mar0), .ir_q(ir0), .y_q(y0),
        .mbr_q(mbr0), .ready(ready0), .bus_err(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic view_t dut_view();
        view_t v;
        v.pc = pc1; v.mar = mar1; v.ir = ir1; v.y = y1; v.mbr = mbr1; v.err = err1;
        return v;
    endfunction

    function automatic view_t model_view();
        view_t v;
        v.pc = m_pc; v.mar = m_mar; v.ir = m_ir; v.y = m_y; v.mbr = m_mbr; v.err = m_err;
        return v;
    endfunction

    function automatic int n_drivers(strobes_t st);
        return int'(st.pc_out) + int'(st.ir_out) + int'(st.dram_out);
    endfunction

    // Bus value the specification prescribes for a given set of drive strobes.
    function automatic logic [7:0] model_bus(strobes_t st);
`ifdef DP_BUS_CHECK_EN
        if (n_drivers(st) >= 2) return 8'h00;
`endif
        if (st.pc_out)   return {4'h0, m_pc};
        if (st.ir_out)   return m_ir;
        if (st.dram_out) return m_mbr;
        return 8'h00;
    endfunction

    task automatic preload(input int a, input logic [7:0] v);
        u_dut.mem_q[a] = v;
        m_mem[a] = v;
    endtask

    // One register-transfer cycle (no memory request), checked against the model.
    task automatic reg_cycle(input strobes_t st, input string tag);
        logic [7:0] b;
        view_t got, exp;
        st.en = 1'b0; st.data_in = 1'b0; st.data_out = 1'b0;
        s1 = st;
        #1;
        b = model_bus(st);
        n_cmp++;
        if (bus1 !== b) begin
            n_bad++;
            $display("FAIL %s bus: got %h expected %h", tag, bus1, b);
        end
`ifdef DP_BUS_CHECK_EN
        if (n_drivers(st) >= 2) m_err = 1'b1;
`endif
        if (st.pc_in) m_pc = b[3:0];
        else if (st.inc_pc) m_pc = 4'(m_pc + 4'd1);
        if (st.mar_in)  m_mar = b[3:0];
        if (st.ir_in)   m_ir = b;
        if (st.y_in)    m_y = b;
        if (st.dram_in) m_mbr = b;
        tick();
        s1 = '0;
        got = dut_view();
        exp = model_view();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s regs: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pc(input logic [3:0] v);
        strobes_t st;
        st = '0;
        st.inc_pc = 1'b1;
        while (m_pc != v) reg_cycle(st, "set_pc");
    endtask

    // Full memory transaction on the WAIT_CYC=1 instance, with latency checks.
    task automatic mem_op(input bit wr, input bit rd, input bit use_mar,
                          input bit bogus, input string tag);
        logic [3:0] addr;
        logic [7:0] wdata;
        int k;
        view_t got, exp;
        addr  = use_mar ? m_mar : m_pc;
        wdata = m_mbr;
        s1 = '0;
        s1.en = 1'b1; s1.data_in = wr; s1.data_out = rd; s1.mar_sel = use_mar;
        tick();
        s1 = '0;
`ifdef DP_BUS_CHECK_EN
        if (wr && rd) m_err = 1'b1;
`endif
        k = 0;
        while (ready1 !== 1'b1 && k < 20) begin
            if (bogus) begin
                s1.en = 1'b1; s1.data_in = 1'b1; s1.data_out = 1'b1; s1.mar_sel = ~use_mar;
            end
            tick();
            s1 = '0;
            k++;
        end
        n_cmp++;
        if (k != WAIT1) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles expected %0d", tag, k, WAIT1);
        end
        tick();
        if (wr) m_mem[addr] = wdata;
        else    m_mbr = m_mem[addr];
        n_cmp++;
        if (ready1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_pulse: got %b expected 0", tag, ready1);
        end
        got = dut_view();
        exp = model_view();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s regs: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic test_reset_chk(input string tag);
        view_t got;
        s1 = '0; s0 = '0;
        reset = 1'b0;
        #2;
        m_pc = '0; m_mar = '0; m_ir = '0; m_y = '0; m_mbr = '0; m_err = 1'b0;
        got = dut_view();
        n_cmp++;
        if (got !== '0 || bus1 !== 8'h00 || ready1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: regs %h bus %h ready %b expected all zero", tag, got, bus1, ready1);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        strobes_t st;
        test_reset_chk("reset_initial");
        preload(3, 8'h11);
        preload(9, 8'h66);
        set_pc(4'd9);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "rd9");
        set_pc(4'd3);
        st = '0; st.pc_out = 1'b1; st.mar_in = 1'b1;
        reg_cycle(st, "mar3");
        // write MBR=66 to addr 3, then abort from inside BUSY
        s1 = '0; s1.en = 1'b1; s1.data_in = 1'b1; s1.mar_sel = 1'b1;
        tick();
        s1 = '0;
        test_reset_chk("reset_mid_write");
        set_pc(4'd3);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "rd3_after_abort");
        n_cmp++;
        if (mbr1 !== 8'h11) begin
            n_bad++;
            $display("FAIL abort_no_write: got %h expected 11", mbr1);
        end
    endtask

    task automatic test_fetch();
        strobes_t st;
        test_reset_chk("reset_fetch");
        preload(2, 8'hA5);
        set_pc(4'd2);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "fetch");
        st = '0; st.dram_out = 1'b1; st.ir_in = 1'b1;
        reg_cycle(st, "fetch_ir");
        n_cmp++;
        if (ir1 !== 8'hA5) begin
            n_bad++;
            $display("FAIL fetch_ir_value: got %h expected a5", ir1);
        end
    endtask

    task automatic test_pc_wrap();
        strobes_t st;
        set_pc(4'hF);
        st = '0; st.inc_pc = 1'b1;
        reg_cycle(st, "pc_wrap");
        n_cmp++;
        if (pc1 !== 4'h0) begin
            n_bad++;
            $display("FAIL pc_wrap_value: got %h expected 0", pc1);
        end
        set_pc(4'd5);
        st = '0; st.pc_out = 1'b1; st.ir_in = 1'b1;
        reg_cycle(st, "ir5");
        set_pc(4'd6);
        st = '0; st.ir_out = 1'b1; st.pc_in = 1'b1; st.inc_pc = 1'b1;
        reg_cycle(st, "pc_load_prio");
        n_cmp++;
        if (pc1 !== 4'd5) begin
            n_bad++;
            $display("FAIL pc_load_prio_value: got %h expected 5", pc1);
        end
    endtask

    task automatic test_write_read();
        strobes_t st;
        preload(1, 8'h3C);
        set_pc(4'd1);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "load3c");
        set_pc(4'd7);
        st = '0; st.pc_out = 1'b1; st.mar_in = 1'b1;
        reg_cycle(st, "mar7");
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, "write7");
        st = '0; st.dram_in = 1'b1;
        reg_cycle(st, "mbr_clear");
        mem_op(1'b0, 1'b1, 1'b1, 1'b0, "read7");
        n_cmp++;
        if (mbr1 !== 8'h3C) begin
            n_bad++;
            $display("FAIL read7_value: got %h expected 3c", mbr1);
        end
    endtask

    task automatic test_mbr_priority();
        preload(4, 8'hC3);
        set_pc(4'd4);
        s1 = '0; s1.en = 1'b1; s1.data_out = 1'b1;
        tick();
        s1 = '0; s1.dram_in = 1'b1; s1.pc_out = 1'b1;
        tick();                                   // BUSY edge: bus load of PC
        n_cmp++;
        if (mbr1 !== 8'h04 || ready1 !== 1'b1) begin
            n_bad++;
            $display("FAIL mbr_busy_load: got mbr %h ready %b expected 04 1", mbr1, ready1);
        end
        tick();                                   // DONE edge: memory wins
        s1 = '0;
        m_mbr = 8'hC3;
        n_cmp++;
        if (mbr1 !== 8'hC3) begin
            n_bad++;
            $display("FAIL mbr_done_priority: got %h expected c3", mbr1);
        end
    endtask

    task automatic test_bus_conflict();
        strobes_t st;
        logic [7:0] exp_y;
        logic       exp_err;
        test_reset_chk("reset_conflict");
        set_pc(4'd6);
        st = '0; st.pc_out = 1'b1; st.ir_in = 1'b1;
        reg_cycle(st, "ir6");
        set_pc(4'd9);
        st = '0; st.pc_out = 1'b1; st.ir_out = 1'b1; st.y_in = 1'b1;
        reg_cycle(st, "conflict");
`ifdef DP_BUS_CHECK_EN
        exp_y = 8'h00; exp_err = 1'b1;
`else
        exp_y = 8'h09; exp_err = 1'b0;
`endif
        n_cmp++;
        if (y1 !== exp_y || err1 !== exp_err) begin
            n_bad++;
            $display("FAIL conflict_result: got y %h err %b expected %h %b", y1, err1, exp_y, exp_err);
        end
        st = '0;
        reg_cycle(st, "err_sticky");
        n_cmp++;
        if (err1 !== exp_err) begin
            n_bad++;
            $display("FAIL err_sticky: got %b expected %b", err1, exp_err);
        end
        // read+write request: write must win
        preload(9, 8'h5E);
        preload(10, 8'h21);
        set_pc(4'd10);
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "rd10");
        set_pc(4'd9);
        mem_op(1'b1, 1'b1, 1'b0, 1'b0, "rw_conflict");
        st = '0; st.dram_in = 1'b1;
        reg_cycle(st, "mbr_clear2");
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, "rd9_back");
        n_cmp++;
        if (mbr1 !== 8'h21) begin
            n_bad++;
            $display("FAIL write_wins: got %h expected 21", mbr1);
        end
    endtask

    task automatic test_random();
        strobes_t st;
        for (int a = 0; a < 16; a++) preload(a, 8'($urandom));
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                st = '0;
                st.pc_out   = ($urandom_range(0, 2) == 0);
                st.ir_out   = ($urandom_range(0, 2) == 0);
                st.dram_out = ($urandom_range(0, 2) == 0);
                st.pc_in    = ($urandom_range(0, 3) == 0);
                st.inc_pc   = ($urandom_range(0, 2) == 0);
                st.mar_in   = ($urandom_range(0, 2) == 0);
                st.ir_in    = ($urandom_range(0, 2) == 0);
                st.y_in     = ($urandom_range(0, 2) == 0);
                st.dram_in  = ($urandom_range(0, 2) == 0);
                reg_cycle(st, "rand_reg");
            end else begin
                bit wr, rd;
                wr = 1'($urandom_range(0, 1));
                rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
                mem_op(wr, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_mem");
            end
        end
    endtask

    task automatic test_back_to_back();
        // zero-wait instance: a held request completes every other cycle
        u_dut0.mem_q[0] = 8'h5A;
        s0 = '0; s0.en = 1'b1; s0.data_out = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (ready0 !== ((i % 2) == 0)) begin
                n_bad++;
                $display("FAIL b2b_ready[%0d]: got %b expected %b", i, ready0, (i % 2) == 0);
            end
        end
        s0 = '0;
        n_cmp++;
        if (mbr0 !== 8'h5A) begin
            n_bad++;
            $display("FAIL b2b_mbr: got %h expected 5a", mbr0);
        end
        s0.inc_pc = 1'b1;
        tick();
        s0 = '0; s0.en = 1'b1; s0.data_in = 1'b1;
        tick();
        s0 = '0;
        n_cmp++;
        if (ready0 !== 1'b1) begin
            n_bad++;
            $display("FAIL zw_write_ready: got %b expected 1", ready0);
        end
        tick();
        s0.dram_in = 1'b1;
        tick();
        s0 = '0; s0.en = 1'b1; s0.data_out = 1'b1;
        n_cmp++;
        if (mbr0 !== 8'h00) begin
            n_bad++;
            $display("FAIL zw_mbr_clear: got %h expected 00", mbr0);
        end
        tick();
        s0 = '0;
        tick();
        n_cmp++;
        if (mbr0 !== 8'h5A || ready0 !== 1'b0) begin
            n_bad++;
            $display("FAIL zw_readback: got mbr %h ready %b expected 5a 0", mbr0, ready0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_pc_wrap();
        test_write_read();
        test_mbr_priority();
        test_bus_conflict();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Datapath side of the processor's control interface: consumes the strobes issued by the sequencing controller (PC/MAR/IR/Y/MBR load and drive, memory read/write, enable) and implements the registers, the shared internal bus and a single-port word RAM behind a wait-state handshake. It returns `ready` so the controller can stall a state until a memory access completes, and flags illegal multi-driver bus cycles.

## Interface
Parameters:
- `WIDTH`, 8, data/bus width in bits
- `AW`, 4, address width; RAM holds 2**AW words
- `WAIT_CYC`, 1, extra cycles per memory access (0..15)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `PC_in` / `PC_out`  in  1  load PC from bus / drive PC onto bus
- `inc_PC`  in  1  PC increment
- `MAR_in`  in  1  load MAR from bus[AW-1:0]
- `MAR_mramout`  in  1  memory address source: 1 = MAR, 0 = PC
- `dram_in` / `dram_out`  in  1  load MBR from bus / drive MBR onto bus
- `data_in`  in  1  memory write request (MBR -> RAM)
- `data_out`  in  1  memory read request (RAM -> MBR)
- `en`  in  1  memory access enable; qualifies `data_in`/`data_out`
- `IR_in` / `IR_out`  in  1  load IR from bus / drive IR onto bus
- `Y_in`  in  1  load Y from bus
- `bus`  out  WIDTH  current internal bus value
- `pc_q`, `mar_q`  out  AW  PC, MAR contents
- `ir_q`, `y_q`, `mbr_q`  out  WIDTH  IR, Y, MBR contents
- `ready`  out  1  one-cycle pulse: memory access complete
- `bus_err`  out  1  sticky multi-driver error

## Operation
- Bus: combinational mux of PC (zero-extended), IR, MBR selected by `PC_out`, `IR_out`, `dram_out`; no driver -> bus = 0.
- Register loads on rising edge when their `_in` strobe is high, sampling the bus value of that cycle. Same-cycle drive and load of one register (e.g. `IR_out`&`IR_in`) keeps value.
- PC: `PC_in` has priority over `inc_PC`; increment wraps 2**AW-1 -> 0.
- Memory FSM states IDLE, BUSY, DONE:
  - IDLE: when `en` & (`data_in` | `data_out`), latch address (MAR or PC per `MAR_mramout`), direction and, for write, MBR value; go to BUSY with wait counter = WAIT_CYC, or DONE directly if WAIT_CYC = 0.
  - BUSY: decrement counter; at 1 -> DONE. Strobes ignored.
  - DONE: perform access (read -> MBR, write -> RAM[addr]), `ready`=1 for that cycle, -> IDLE.
  - `data_in` & `data_out` together in IDLE: write wins, `bus_err` set.
- `dram_in` during BUSY/DONE of a read: DONE's memory load wins over bus load on the DONE edge.
- RAM contents not reset; undefined until written.

## Timing
- Reset (async assert, sync release): PC=0, MAR=0, IR=0, Y=0, MBR=0, FSM=IDLE, counter=0, `ready`=0, `bus_err`=0; `bus`=0.
- Reset mid-access aborts: no RAM write, MBR stays 0.
- Access latency: request sampled on edge N; `ready` high during cycle after edge N+WAIT_CYC+1... precisely: FSM enters DONE after edge N+WAIT_CYC, MBR/RAM update on edge N+WAIT_CYC+1, `ready` high in the cycle preceding that edge.
- Back-to-back: new request accepted earliest the edge after DONE (one idle cycle minimum).
- Register loads: value visible on `*_q` one edge after strobe.

## Configuration
- `DP_BUS_CHECK_EN` defined: two or more of `PC_out`/`IR_out`/`dram_out` high forces bus = 0, sets `bus_err` (sticky until reset), and any load that cycle stores 0; read+write conflict also sets `bus_err`.
- Undefined: `bus_err` tied 0; multi-driver resolves by fixed priority PC > IR > MBR; read+write conflict still resolves write-wins.

## Test plan
- Reset: assert `reset`=0 mid-BUSY of write to addr 3 -> all `*_q`=0, `ready`=0; later read of addr 3 confirms no write occurred.
- Fetch: PC=2 via bus, `en`&`data_out`, `MAR_mramout`=0, RAM[2]=8'hA5, WAIT_CYC=1 -> `ready` pulses 2 cycles after request, MBR=8'hA5; `dram_out`+`IR_in` -> ir_q=8'hA5.
- PC wrap: PC=4'hF, `inc_PC` -> pc_q=0; `PC_in`+`inc_PC` with bus=5 -> pc_q=5.
- Write then read: MBR=8'h3C, MAR=7, write; MBR cleared; read MAR=7 -> MBR=8'h3C; strobes during BUSY ignored.
- Bus conflict (macro on): `PC_out`&`IR_out` with `Y_in` -> bus=0, y_q=0, `bus_err`=1 and stays 1; macro off -> bus=PC, `bus_err`=0.
- WAIT_CYC=0: request -> `ready` in next cycle; back-to-back requests accepted one cycle apart after DONE.
